irq_arbiter: RTL and testbench

Machine-external interrupt arbiter that sits between the external interrupt lines and the core's trap-entry logic, beside the CSR file. It captures rising edges on up to eight interrupt sources into pending bits and masks them with the interrupt-enable vector. It selects one winner and runs a request/acknowledge/return handshake with the core, so exactly one interrupt is in service at a time. It also supplies the cause value the CSR file loads into mcause on trap entry.

---
 rtl/irq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: machine-external interrupt arbiter between the external
// interrupt lines and the core's trap-entry logic.
//   - Rising edges on i_MEI set pending bits; eligible = pending & i_MIE.
//   - One winner is requested (o_IRQ/o_IRQ_ID); the core acknowledges with
//     i_IRQ_ACK, and i_MRET ends the service. There is no nesting.
//   - o_MCAUSE carries the cause word for mcause while a trap is requested
//     or in service.
// Optional feature macro: IRQ_ARB_ROUND_ROBIN_EN selects round-robin winner
// selection (pointer = acked id + 1). When it is undefined, fixed priority
// is used (index 0 is highest) and no pointer register exists.
// o_DBG_STATE exposes the FSM state (IDLE=0, REQ=1, ACTIVE=2) for observation.
module irq_arbiter #(
  parameter int N_SRC = 6
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [N_SRC-1:0] i_MEI,
  input  logic [N_SRC-1:0] i_MIE,
  input  logic             i_GIE,
  input  logic             i_IRQ_ACK,
  input  logic             i_MRET,
  output logic             o_IRQ,
  output logic [2:0]       o_IRQ_ID,
  output logic             o_ACTIVE,
  output logic [N_SRC-1:0] o_PENDING,
  output logic [31:0]      o_MCAUSE,
  output logic [1:0]       o_DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] mei_q;
  logic [N_SRC-1:0] pending;
  logic [2:0]       id_q;
  logic             irq_q;
  logic             active_q;
  logic [31:0]      mcause_q;

  logic [N_SRC-1:0] edge_v;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_oh;
  logic [N_SRC-1:0] ack_clr;
  logic             ack_take;
  logic             id_eligible;
  logic [2:0]       win_id;
  logic             win_found;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [2:0]       rr_ptr;
  logic [2:0]       rr_next;
`endif

  // Handshake: o_IRQ acts as "valid" and i_IRQ_ACK as the accepting pulse.
  // While o_IRQ is high, o_IRQ_ID is held stable; the request ends either on
  // the ack (transfer taken, enter ACTIVE) or on withdrawal when the source
  // becomes ineligible or i_GIE drops. Ack wins over withdrawal in one cycle.

  // Edge detect, id decode and eligibility of the registered winner
  always_comb begin
    edge_v   = i_MEI & ~mei_q;
    eligible = pending & i_MIE;
    id_oh    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      id_oh[k] = (id_q == 3'(k));
    end
    ack_take    = (state == S_REQ) && i_IRQ_ACK;
    ack_clr     = ack_take ? id_oh : '0;
    id_eligible = |(eligible & id_oh);
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  // Round-robin winner: lowest eligible index at or above the pointer,
  // otherwise wrap and take the lowest eligible index overall
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!win_found && eligible[k] && (3'(k) >= rr_ptr)) begin
        win_found = 1'b1;
        win_id    = 3'(k);
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (!win_found && eligible[k]) begin
        win_found = 1'b1;
        win_id    = 3'(k);
      end
    end
    rr_next = (id_q == 3'(N_SRC - 1)) ? 3'd0 : id_q + 3'd1;
  end
`else
  // Fixed-priority winner: lowest eligible index
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!win_found && eligible[k]) begin
        win_found = 1'b1;
        win_id    = 3'(k);
      end
    end
  end
`endif

  // Edge capture into pending; a new edge on the acked bit wins over the clear
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      mei_q   <= '0;
      pending <= '0;
    end else begin
      mei_q   <= i_MEI;
      pending <= (pending & ~ack_clr) | edge_v;
    end
  end

  // Request/ack/return FSM with registered outputs
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= S_IDLE;
      id_q     <= '0;
      irq_q    <= 1'b0;
      active_q <= 1'b0;
      mcause_q <= '0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_GIE && win_found) begin
            state    <= S_REQ;
            id_q     <= win_id;
            irq_q    <= 1'b1;
            mcause_q <= {1'b1, 28'd0, win_id};
          end
        end
        S_REQ: begin
          if (i_IRQ_ACK) begin
            state    <= S_ACTIVE;
            irq_q    <= 1'b0;
            active_q <= 1'b1;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
            rr_ptr   <= rr_next;
`endif
          end else if (!id_eligible || !i_GIE) begin
            state    <= S_IDLE;
            irq_q    <= 1'b0;
            mcause_q <= '0;
          end
        end
        S_ACTIVE: begin
          if (i_MRET) begin
            state    <= S_IDLE;
            active_q <= 1'b0;
            mcause_q <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          irq_q    <= 1'b0;
          active_q <= 1'b0;
          mcause_q <= '0;
        end
      endcase
    end
  end

  assign o_IRQ       = irq_q;
  assign o_IRQ_ID    = id_q;
  assign o_ACTIVE    = active_q;
  assign o_PENDING   = pending;
  assign o_MCAUSE    = mcause_q;
  assign o_DBG_STATE = state;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenario tasks plus a randomized run checked
// against a behavioural model of the arbiter rules. Inputs change on the
// falling edge; outputs are sampled on the following falling edge.
// Honours IRQ_ARB_ROUND_ROBIN_EN for the expected winner order.
module tb_irq_arbiter;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] mei;
  logic [N-1:0] mie;
  logic         gie;
  logic         ack;
  logic         mret;
  logic         o_irq;
  logic [2:0]   o_irq_id;
  logic         o_active;
  logic [N-1:0] o_pending;
  logic [31:0]  o_mcause;
  logic [1:0]   o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Snapshot layout: {irq, id, active, pending, mcause}
  wire [42:0] snap = {o_irq, o_irq_id, o_active, o_pending, o_mcause};

  irq_arbiter #(.N_SRC(N)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_MEI       (mei),
    .i_MIE       (mie),
    .i_GIE       (gie),
    .i_IRQ_ACK   (ack),
    .i_MRET      (mret),
    .o_IRQ       (o_irq),
    .o_IRQ_ID    (o_irq_id),
    .o_ACTIVE    (o_active),
    .o_PENDING   (o_pending),
    .o_MCAUSE    (o_mcause),
    .o_DBG_STATE (o_dbg_state)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; mei = '0; mie = '0; gie = 1'b0; ack = 1'b0; mret = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_prev, m_pend;
  logic         m_req, m_busy;
  logic [2:0]   m_id;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [2:0]   m_ptr;
`endif

  function automatic void model_reset();
    m_prev = '0; m_pend = '0; m_req = 1'b0; m_busy = 1'b0; m_id = '0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    m_ptr = '0;
`endif
  endfunction

  // One clock of the arbiter rules, applied to the inputs seen at that edge
  function automatic void model_step(input logic [N-1:0] mei_v, input logic [N-1:0] mie_v,
                                     input logic gie_v, input logic ack_v, input logic mret_v);
    logic [N-1:0] elig, edges, clr;
    logic [2:0]   start;
    int           idx;
    logic         found;
    elig  = m_pend & mie_v;
    edges = mei_v & ~m_prev;
    clr   = '0;
    if (m_req && ack_v) clr[m_id] = 1'b1;
    m_pend = (m_pend & ~clr) | edges;
    m_prev = mei_v;
    if (m_req) begin
      if (ack_v) begin
        m_req  = 1'b0;
        m_busy = 1'b1;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        m_ptr  = 3'((int'(m_id) + 1) % N);
`endif
      end else if (!elig[m_id] || !gie_v) begin
        m_req = 1'b0;
      end
    end else if (m_busy) begin
      if (mret_v) m_busy = 1'b0;
    end else if (gie_v && (elig != '0)) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 3'd0;
`endif
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        idx = (int'(start) + j) % N;
        if (!found && elig[idx[2:0]]) begin
          found = 1'b1;
          m_id  = idx[2:0];
        end
      end
      m_req = 1'b1;
    end
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (snap !== 43'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", snap, 43'd0);
    end
  endtask

  task automatic test_basic_handshake();
    do_reset(); mie = 6'h3F; gie = 1'b1; tick();
    mei = 6'b000100; tick();
    n_checks++;
    if (snap !== {1'b0, 3'd0, 1'b0, 6'b000100, 32'h0}) begin
      n_fail++; $display("FAIL basic_pending: got %h expected %h", snap, {1'b0, 3'd0, 1'b0, 6'b000100, 32'h0});
    end
    tick();
    n_checks++;
    if (snap !== {1'b1, 3'd2, 1'b0, 6'b000100, 32'h8000_0002}) begin
      n_fail++; $display("FAIL basic_req: got %h expected %h", snap, {1'b1, 3'd2, 1'b0, 6'b000100, 32'h8000_0002});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if (snap !== {1'b0, 3'd2, 1'b1, 6'b000000, 32'h8000_0002}) begin
      n_fail++; $display("FAIL basic_ack: got %h expected %h", snap, {1'b0, 3'd2, 1'b1, 6'b000000, 32'h8000_0002});
    end
    mret = 1'b1; tick(); mret = 1'b0;
    n_checks++;
    if (snap !== {1'b0, 3'd2, 1'b0, 6'b000000, 32'h0}) begin
      n_fail++; $display("FAIL basic_mret: got %h expected %h", snap, {1'b0, 3'd2, 1'b0, 6'b000000, 32'h0});
    end
    tick(); tick();
    n_checks++;
    if (snap !== {1'b0, 3'd2, 1'b0, 6'b000000, 32'h0}) begin
      n_fail++; $display("FAIL level_held: got %h expected %h", snap, {1'b0, 3'd2, 1'b0, 6'b000000, 32'h0});
    end
    mei = '0;
  endtask

  task automatic test_simultaneous();
    logic [2:0]   first_id, second_id;
    logic [N-1:0] left;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    first_id = 3'd4; second_id = 3'd1; left = 6'b000010;
`else
    first_id = 3'd1; second_id = 3'd4; left = 6'b010000;
`endif
    do_reset(); mie = 6'h3F; gie = 1'b1; tick();
    mei = 6'b001000; tick(); tick();
    n_checks++;
    if (snap !== {1'b1, 3'd3, 1'b0, 6'b001000, 32'h8000_0003}) begin
      n_fail++; $display("FAIL prior_req: got %h expected %h", snap, {1'b1, 3'd3, 1'b0, 6'b001000, 32'h8000_0003});
    end
    ack = 1'b1; mei = '0; tick(); ack = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0;
    mei = 6'b010010; tick(); tick();
    n_checks++;
    if (snap !== {1'b1, first_id, 1'b0, 6'b010010, 1'b1, 28'd0, first_id}) begin
      n_fail++; $display("FAIL simul_first: got %h expected %h", snap, {1'b1, first_id, 1'b0, 6'b010010, 1'b1, 28'd0, first_id});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if (snap !== {1'b0, first_id, 1'b1, left, 1'b1, 28'd0, first_id}) begin
      n_fail++; $display("FAIL simul_ack: got %h expected %h", snap, {1'b0, first_id, 1'b1, left, 1'b1, 28'd0, first_id});
    end
    mret = 1'b1; tick(); mret = 1'b0; tick();
    n_checks++;
    if (snap !== {1'b1, second_id, 1'b0, left, 1'b1, 28'd0, second_id}) begin
      n_fail++; $display("FAIL simul_second: got %h expected %h", snap, {1'b1, second_id, 1'b0, left, 1'b1, 28'd0, second_id});
    end
  endtask

  task automatic test_masking();
    do_reset(); mie = 6'b011111; gie = 1'b1; tick();
    mei = 6'b100000; tick(); tick();
    n_checks++;
    if (snap !== {1'b0, 3'd0, 1'b0, 6'b100000, 32'h0}) begin
      n_fail++; $display("FAIL masked: got %h expected %h", snap, {1'b0, 3'd0, 1'b0, 6'b100000, 32'h0});
    end
    mie = 6'h3F; tick();
    n_checks++;
    if (snap !== {1'b1, 3'd5, 1'b0, 6'b100000, 32'h8000_0005}) begin
      n_fail++; $display("FAIL unmask_req: got %h expected %h", snap, {1'b1, 3'd5, 1'b0, 6'b100000, 32'h8000_0005});
    end
    mie = 6'b011111; tick();
    n_checks++;
    if (snap !== {1'b0, 3'd5, 1'b0, 6'b100000, 32'h0}) begin
      n_fail++; $display("FAIL withdraw_mask: got %h expected %h", snap, {1'b0, 3'd5, 1'b0, 6'b100000, 32'h0});
    end
    mie = 6'h3F; tick(); gie = 1'b0; tick();
    n_checks++;
    if (snap !== {1'b0, 3'd5, 1'b0, 6'b100000, 32'h0}) begin
      n_fail++; $display("FAIL withdraw_gie: got %h expected %h", snap, {1'b0, 3'd5, 1'b0, 6'b100000, 32'h0});
    end
    gie = 1'b1; mei = '0;
  endtask

  task automatic test_no_nesting();
    do_reset(); mie = 6'h3F; gie = 1'b1; tick();
    mei = 6'b000001; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    mei = 6'b001001; tick(); tick();
    n_checks++;
    if (snap !== {1'b0, 3'd0, 1'b1, 6'b001000, 32'h8000_0000}) begin
      n_fail++; $display("FAIL nest_hold: got %h expected %h", snap, {1'b0, 3'd0, 1'b1, 6'b001000, 32'h8000_0000});
    end
    mret = 1'b1; tick(); mret = 1'b0;
    n_checks++;
    if (snap !== {1'b0, 3'd0, 1'b0, 6'b001000, 32'h0}) begin
      n_fail++; $display("FAIL nest_idle: got %h expected %h", snap, {1'b0, 3'd0, 1'b0, 6'b001000, 32'h0});
    end
    tick();
    n_checks++;
    if (snap !== {1'b1, 3'd3, 1'b0, 6'b001000, 32'h8000_0003}) begin
      n_fail++; $display("FAIL nest_rereq: got %h expected %h", snap, {1'b1, 3'd3, 1'b0, 6'b001000, 32'h8000_0003});
    end
    mei = '0;
  endtask

  task automatic test_same_cycle_set_clear();
    do_reset(); mie = 6'h3F; gie = 1'b1; tick();
    mei = 6'b000100; tick(); tick();
    mei = '0; tick();
    mei = 6'b000100; ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if (snap !== {1'b0, 3'd2, 1'b1, 6'b000100, 32'h8000_0002}) begin
      n_fail++; $display("FAIL sc_ack: got %h expected %h", snap, {1'b0, 3'd2, 1'b1, 6'b000100, 32'h8000_0002});
    end
    mret = 1'b1; tick(); mret = 1'b0; tick();
    n_checks++;
    if (snap !== {1'b1, 3'd2, 1'b0, 6'b000100, 32'h8000_0002}) begin
      n_fail++; $display("FAIL sc_rereq: got %h expected %h", snap, {1'b1, 3'd2, 1'b0, 6'b000100, 32'h8000_0002});
    end
    mei = '0;
  endtask

  task automatic test_reset_mid();
    do_reset(); mie = 6'h3F; gie = 1'b1; tick();
    mei = 6'b000001; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    mei = 6'b010011; tick();
    n_checks++;
    if (snap !== {1'b0, 3'd0, 1'b1, 6'b010010, 32'h8000_0000}) begin
      n_fail++; $display("FAIL rm_pend: got %h expected %h", snap, {1'b0, 3'd0, 1'b1, 6'b010010, 32'h8000_0000});
    end
    rst = 1'b1; mei = '0; tick(); rst = 1'b0;
    n_checks++;
    if (snap !== 43'd0) begin
      n_fail++; $display("FAIL rm_reset: got %h expected %h", snap, 43'd0);
    end
    mret = 1'b1; tick(); mret = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0; tick();
    n_checks++;
    if (snap !== 43'd0) begin
      n_fail++; $display("FAIL rm_spurious: got %h expected %h", snap, 43'd0);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] cur_mei;
    logic [N-1:0] flip;
    logic [42:0]  exp;
    do_reset(); model_reset();
    cur_mei = '0;
    for (int c = 0; c < 1500; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip = {flip[N-2:0], ($urandom_range(0, 5) == 0)};
      cur_mei = cur_mei ^ flip;
      mei  = cur_mei;
      mie  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
      gie  = ($urandom_range(0, 9) != 0);
      ack  = m_req  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      mret = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      model_step(mei, mie, gie, ack, mret);
      tick();
      exp = {m_req, m_id, m_busy, m_pend, ((m_req || m_busy) ? {1'b1, 28'd0, m_id} : 32'h0)};
      n_checks++;
      if (snap !== exp) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL random cycle %0d: got %h expected %h", c, snap, exp);
      end
    end
    ack = 1'b0; mret = 1'b0; mei = '0;
  endtask

  initial begin
    test_reset();
    test_basic_handshake();
    test_simultaneous();
    test_masking();
    test_no_nesting();
    test_same_cycle_set_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
